branch_pred_ctrl: RTL and testbench

//  Dynamic branch-prediction controller for the 5-stage forwarding pipeline.

---
 rtl/branch_pred_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pred_ctrl
//
// Dynamic branch-prediction controller for a 5-stage forwarding pipeline.
//
// Prediction (IF, combinational):
//   A tagless branch history table (BHT) of 2-bit saturating counters is
//   indexed by if_pc[BHT_IDX_W+1:2]. An entry that has never been trained
//   falls back to the static backward-taken / forward-not-taken policy, using
//   the sign of the branch immediate. A trained entry uses the counter MSB
//   instead. JAL is always predicted taken.
//
// Resolution (EX, registered):
//   A live branch in EX updates its BHT entry and the branch counter. When the
//   resolved direction differs from the prediction carried down from IF, the
//   block raises a one-cycle redirect with the corrected PC and holds both
//   squash strobes high for FLUSH_LEN cycles. While the flush window is open
//   (FLUSH state) everything arriving on the ex_* inputs is a wrong-path
//   instruction and is ignored.
//
// Parameters:
//   BHT_IDX_W  BHT index width; the table has 2**BHT_IDX_W entries
//   FLUSH_LEN  cycles the flush strobes stay high after a mispredict (1..7)
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   if_pc, if_is_branch,
//   if_is_jal, if_target,
//   if_imm_neg                   IF-stage instruction being fetched
//   pred_taken                   prediction for the IF instruction (comb)
//   next_pc                      PC to fetch next cycle (comb)
//   ex_valid, ex_is_branch,
//   ex_pc, ex_taken, ex_target,
//   ex_pred_taken                EX-stage resolved branch information
//   redirect_valid, redirect_pc  registered fetch redirect after a mispredict
//   flush_if_id, flush_id_ex     registered squash strobes
//   br_cnt, mis_cnt              saturating resolved-branch / mispredict counts
// -----------------------------------------------------------------------------
module branch_pred_ctrl #(
  parameter int BHT_IDX_W = 4,
  parameter int FLUSH_LEN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // IF stage
  input  logic [31:0] if_pc,
  input  logic        if_is_branch,
  input  logic        if_is_jal,
  input  logic [31:0] if_target,
  input  logic        if_imm_neg,
  output logic        pred_taken,
  output logic [31:0] next_pc,
  // EX stage
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  // Redirect / flush
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  // Statistics
  output logic [15:0] br_cnt,
  output logic [15:0] mis_cnt
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_W;

  // Flush counter is loaded with FLUSH_LEN-1 and counts down to zero; the
  // strobes are high for every cycle the FLUSH state lasts.
  localparam logic [2:0] FC_INIT = 3'(FLUSH_LEN - 1);
  // With a single-cycle flush there is nothing to wait for: stay in RUN.
  localparam bit MULTI_CYCLE_FLUSH = (FLUSH_LEN > 1);

  // Counter encodings
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state, state_next;
  logic [2:0]             fc, fc_next;

  logic [BHT_DEPTH-1:0]   bht_valid;
  logic [1:0]             bht_ctr [BHT_DEPTH];

  logic                   redirect_valid_next;
  logic [31:0]            redirect_pc_next;
  logic                   flush_q, flush_next;

  // ---------------------------------------------------------------------------
  // IF-stage prediction
  // ---------------------------------------------------------------------------
  logic [BHT_IDX_W-1:0]   if_idx;
  logic                   dir_taken;
  logic [31:0]            if_seq_pc;

  assign if_idx    = if_pc[BHT_IDX_W+1:2];
  assign if_seq_pc = if_pc + 32'd4;

  // The table is read from registers, so a same-cycle EX update of this entry
  // is seen only from the next cycle on (no bypass).
  assign dir_taken  = bht_valid[if_idx] ? bht_ctr[if_idx][1] : if_imm_neg;
  assign pred_taken = if_is_jal | (if_is_branch & dir_taken);

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here via the if/else chain, elsewhere via defaults at the top); a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (pred_taken) begin
      next_pc = if_target;
    end else begin
      next_pc = if_seq_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // EX-stage resolution
  // ---------------------------------------------------------------------------
  logic [BHT_IDX_W-1:0]   ex_idx;
  logic                   resolve;
  logic                   mispredict;
  logic [1:0]             ctr_upd;

  assign ex_idx = ex_pc[BHT_IDX_W+1:2];

  // Only RUN accepts EX results; during FLUSH the EX slot holds wrong-path work.
  assign resolve    = (state == ST_RUN) & ex_valid & ex_is_branch;
  assign mispredict = resolve & (ex_taken != ex_pred_taken);

  // First resolution seeds the entry in the weak state of the observed
  // direction; later ones saturate towards 00 / 11.
  always_comb begin
    ctr_upd = bht_ctr[ex_idx];
    if (!bht_valid[ex_idx]) begin
      ctr_upd = ex_taken ? CTR_WEAK_T : CTR_WEAK_NT;
    end else if (ex_taken) begin
      if (bht_ctr[ex_idx] != CTR_STRONG_T) begin
        ctr_upd = bht_ctr[ex_idx] + 2'd1;
      end
    end else begin
      if (bht_ctr[ex_idx] != CTR_STRONG_NT) begin
        ctr_upd = bht_ctr[ex_idx] - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking (<=)
  // assignments so every flop samples pre-edge values; blocking (=) is kept
  // for combinational blocks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      fc    <= 3'd0;
    end else begin
      state <= state_next;
      fc    <= fc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    fc_next    = fc;
    unique case (state)
      ST_RUN: begin
        if (mispredict) begin
          fc_next    = FC_INIT;
          state_next = MULTI_CYCLE_FLUSH ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (fc == 3'd0) begin
          state_next = ST_RUN;
        end else begin
          fc_next = fc - 3'd1;
        end
      end
      default: begin
        state_next = ST_RUN;
        fc_next    = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (values the registered outputs take at the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc;
    flush_next          = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mispredict) begin
          redirect_valid_next = 1'b1;
          redirect_pc_next    = ex_taken ? ex_target : (ex_pc + 32'd4);
          flush_next          = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Strobes stay up until the last FLUSH cycle (fc == 0) has passed.
        flush_next = (fc != 3'd0);
      end
      default: begin
        flush_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush_q        <= 1'b0;
    end else begin
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
      flush_q        <= flush_next;
    end
  end

  // Both pipeline registers are squashed over the same window.
  assign flush_if_id = flush_q;
  assign flush_id_ex = flush_q;

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  // NOTE: the table is small and held in flops, so it is reset explicitly:
  // the untrained/static fallback depends on every valid bit starting at 0.
  // A large RAM-based table would instead be cleared by a sequenced walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_valid <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_ctr[i] <= CTR_WEAK_NT;
      end
    end else if (resolve) begin
      bht_valid[ex_idx] <= 1'b1;
      bht_ctr[ex_idx]   <= ctr_upd;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= 16'd0;
      mis_cnt <= 16'd0;
    end else begin
      if (resolve && (br_cnt != CNT_MAX)) begin
        br_cnt <= br_cnt + 16'd1;
      end
      if (mispredict && (mis_cnt != CNT_MAX)) begin
        mis_cnt <= mis_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_ctrl
//
// Self-checking bench for branch_pred_ctrl (FLUSH_LEN = 3). A behavioural
// reference model tracks the BHT, counters and flush window. Each cycle the
// expected combinational outputs are queued and compared shortly after the
// inputs are applied; the expected registered outputs for the next cycle are
// queued at the same time and compared one clock later.
// -----------------------------------------------------------------------------
module tb_branch_pred_ctrl;

  localparam int BHT_IDX_W = 4;
  localparam int FLUSH_LEN = 3;
  localparam int DEPTH     = 1 << BHT_IDX_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic        if_is_jal;
  logic [31:0] if_target;
  logic        if_imm_neg;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [15:0] br_cnt;
  logic [15:0] mis_cnt;

  always #5 clk = ~clk;

  branch_pred_ctrl #(
    .BHT_IDX_W(BHT_IDX_W),
    .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_is_branch  (if_is_branch),
    .if_is_jal     (if_is_jal),
    .if_target     (if_target),
    .if_imm_neg    (if_imm_neg),
    .pred_taken    (pred_taken),
    .next_pc       (next_pc),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .br_cnt        (br_cnt),
    .mis_cnt       (mis_cnt)
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  typedef enum int {S_PRED, S_NPC, S_RV, S_RPC, S_FLI, S_FLE, S_BR, S_MIS} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_PRED:  return {31'd0, pred_taken};
      S_NPC:   return next_pc;
      S_RV:    return {31'd0, redirect_valid};
      S_RPC:   return redirect_pc;
      S_FLI:   return {31'd0, flush_if_id};
      S_FLE:   return {31'd0, flush_id_ex};
      S_BR:    return {16'd0, br_cnt};
      S_MIS:   return {16'd0, mis_cnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, sample(e.sig), e.val);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic        m_valid [DEPTH];
  logic [1:0]  m_ctr   [DEPTH];
  int          m_br, m_mis;
  int          m_fl;        // flush-high cycles remaining, including this one
  logic        m_rv;
  logic [31:0] m_rpc;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
    end
    m_br  = 0;
    m_mis = 0;
    m_fl  = 0;
    m_rv  = 1'b0;
    m_rpc = 32'd0;
  endtask

  task automatic push_comb(input string tag);
    int          idx;
    logic        tk;
    logic        pred;
    logic [31:0] npc;
    idx  = int'(if_pc[BHT_IDX_W+1:2]);
    tk   = m_valid[idx] ? m_ctr[idx][1] : if_imm_neg;
    pred = if_is_jal | (if_is_branch & tk);
    if (m_rv)      npc = m_rpc;
    else if (pred) npc = if_target;
    else           npc = if_pc + 32'd4;
    push({tag, ".pred"}, S_PRED, {31'd0, pred});
    push({tag, ".npc"},  S_NPC,  npc);
  endtask

  task automatic push_regs(input string tag);
    logic fl;
    fl = (m_fl > 0);
    push({tag, ".rv"},  S_RV,  {31'd0, m_rv});
    push({tag, ".rpc"}, S_RPC, m_rpc);
    push({tag, ".fli"}, S_FLI, {31'd0, fl});
    push({tag, ".fle"}, S_FLE, {31'd0, fl});
    push({tag, ".br"},  S_BR,  m_br);
    push({tag, ".mis"}, S_MIS, m_mis);
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_clock();
    bit   ignore;
    int   nfl;
    logic nrv;
    int   idx;
    ignore = (m_fl > 0) && (FLUSH_LEN > 1);
    nfl    = (m_fl > 0) ? m_fl - 1 : 0;
    nrv    = 1'b0;
    if (ex_valid && ex_is_branch && !ignore) begin
      idx = int'(ex_pc[BHT_IDX_W+1:2]);
      if (m_br < 65535) m_br++;
      if (!m_valid[idx]) begin
        m_valid[idx] = 1'b1;
        m_ctr[idx]   = ex_taken ? 2'b10 : 2'b01;
      end else if (ex_taken) begin
        if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
      end else begin
        if (m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'd1;
      end
      if (ex_taken != ex_pred_taken) begin
        if (m_mis < 65535) m_mis++;
        nrv   = 1'b1;
        m_rpc = ex_taken ? ex_target : ex_pc + 32'd4;
        nfl   = FLUSH_LEN;
      end
    end
    m_fl = nfl;
    m_rv = nrv;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic set_if(input logic [31:0] pc, input logic br, input logic jal,
                        input logic neg, input logic [31:0] tgt);
    if_pc        = pc;
    if_is_branch = br;
    if_is_jal    = jal;
    if_imm_neg   = neg;
    if_target    = tgt;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic pt);
    ex_valid      = v;
    ex_is_branch  = br;
    ex_pc         = pc;
    ex_taken      = tk;
    ex_target     = tgt;
    ex_pred_taken = pt;
  endtask

  // One clock: check comb outputs and last cycle's registered outputs, queue
  // next cycle's registered expectations, and return at the next falling edge.
  task automatic step(input string tag);
    #1;
    if (chk) push_comb(tag);
    drain();
    model_clock();
    if (chk) push_regs(tag);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    set_if(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    push_regs("reset");
    drain();
    rst_n = 1'b1;
    step("idle");

    // Cold prediction: static backward-taken / forward-not-taken
    set_if(32'h40, 1'b1, 1'b0, 1'b1, 32'h20);
    step("cold_bwd");
    set_if(32'h40, 1'b1, 1'b0, 1'b0, 32'h60);
    step("cold_fwd");

    // Train pc 0x40 not-taken twice; counter overrides backward hint
    set_if(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step("nt1");
    step("nt2");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    set_if(32'h40, 1'b1, 1'b0, 1'b1, 32'h20);
    step("trained_nt");

    // JAL always taken; live non-branch in EX changes nothing
    set_if(32'h44, 1'b0, 1'b1, 1'b0, 32'h200);
    set_ex(1'b1, 1'b0, 32'h44, 1'b1, 32'h300, 1'b0);
    step("jal");

    // Taken mispredict at T, flush window T+1..T+3, ignored mispredict at T+2
    set_if(32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    step("mis_T");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("mis_T1");
    set_ex(1'b1, 1'b1, 32'h104, 1'b1, 32'h500, 1'b0);
    step("mis_T2_ign");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("mis_T3");
    step("mis_T4");
    step("mis_T5");

    // Not-taken mispredict: redirect to pc+4
    set_ex(1'b1, 1'b1, 32'h48, 1'b0, 32'h999, 1'b1);
    step("mis_nt");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) step("mis_nt_tail");

    // Same-cycle update and lookup on idx 0 (ctr 01 -> 10): no bypass
    set_if(32'h0, 1'b1, 1'b0, 1'b1, 32'h3c);
    set_ex(1'b1, 1'b1, 32'h0, 1'b1, 32'h3c, 1'b1);
    step("same_cyc");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("after_upd");

    // Async reset in the middle of a flush window
    set_if(32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h10, 1'b1, 32'h70, 1'b0);
    step("rst_mis");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst_T1");
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_reset();
    push_regs("async_rst");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    set_if(32'h0, 1'b1, 1'b0, 1'b0, 32'h40);
    step("post_rst_cold");

    // br_cnt saturation: 65536 resolved branches, then one more
    set_if(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    chk = 1'b0;
    repeat (65536) step("sat_run");
    chk = 1'b1;
    step("sat_hold");
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("sat_end");
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
